// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// The loader uses the master side; the memory's port B uses the slave side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a little-endian program image over a serial
// line and writes it word by word into the instruction memory. The CPU is
// held in reset from the start of a load until the idle timeout ends it.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14,
  parameter int IDLE_TIMEOUT = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uart_rx,
  uart_prog_loader_if.master mem,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic              overflow
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW       = $clog2(CLKS_PER_BIT + 1);
  localparam int IW       = $clog2(IDLE_TIMEOUT + 1);
  localparam int CW       = ADDR_W + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FIRST, ST_LOAD, ST_DONE} state_t;

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_valid;
  logic          frame_pulse;

  state_t        state;
  logic [1:0]    lane;
  logic [31:0]   word_buf;
  logic [IW-1:0] idle_cnt;
  logic          mem_full;

  assign mem_full = word_count[ADDR_W];

  // Bring the asynchronous serial line into the clock domain and keep the
  // previous sample so a genuine high-to-low edge can be detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: validate the start bit at mid-bit, shift in 8 bits LSB-first,
  // then either deliver the byte or flag a framing error from the stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      bit_timer   <= '0;
      bit_idx     <= '0;
      rx_shift    <= '0;
      byte_valid  <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_pulse <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state  <= RX_START;
            bit_timer <= '0;
          end
        end
        RX_START: begin
          if (bit_timer == TW'(HALF_BIT - 1)) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            rx_state  <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        RX_DATA: begin
          if (bit_timer == TW'(CLKS_PER_BIT - 1)) begin
            bit_timer <= '0;
            rx_shift  <= {rx_sync, rx_shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        RX_STOP: begin
          if (bit_timer == TW'(CLKS_PER_BIT - 1)) begin
            bit_timer <= '0;
            rx_state  <= RX_IDLE;
            if (rx_sync) byte_valid  <= 1'b1;
            else         frame_pulse <= 1'b1;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Load controller: arms on start, packs bytes into words, strobes the
  // memory write, flushes a partial word at timeout and then releases the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      mem.wr_en   <= 1'b0;
      mem.wr_addr <= '0;
      mem.wr_data <= '0;
      cpu_rst_n   <= 1'b1;
      loading     <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
      lane        <= '0;
      word_buf    <= '0;
      idle_cnt    <= '0;
    end else begin
      mem.wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_WAIT_FIRST;
            loading    <= 1'b1;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            lane       <= '0;
            word_buf   <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            idle_cnt   <= '0;
          end
        end
        ST_WAIT_FIRST, ST_LOAD: begin
          if (byte_valid) begin
            state    <= ST_LOAD;
            idle_cnt <= '0;
            if (mem_full) begin
              overflow <= 1'b1;
            end else if (lane == 2'd3) begin
              mem.wr_en   <= 1'b1;
              mem.wr_addr <= word_count[ADDR_W-1:0];
              mem.wr_data <= {rx_shift, word_buf[23:0]};
              word_count  <= word_count + CW'(1);
              lane        <= '0;
              word_buf    <= '0;
            end else begin
              word_buf[8*lane +: 8] <= rx_shift;
              lane                  <= lane + 2'd1;
            end
          end else if (state == ST_LOAD) begin
            if (idle_cnt == IW'(IDLE_TIMEOUT)) begin
              state     <= ST_DONE;
              loading   <= 1'b0;
              cpu_rst_n <= 1'b1;
              done      <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
              if (idle_cnt == IW'(IDLE_TIMEOUT - 1) && lane != 2'd0) begin
                mem.wr_en   <= 1'b1;
                mem.wr_addr <= word_count[ADDR_W-1:0];
                mem.wr_data <= word_buf;
                word_count  <= word_count + CW'(1);
                lane        <= '0;
                word_buf    <= '0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (frame_pulse) frame_err <= 1'b1;
    end
  end

endmodule
